// File: rtl/hilo_pkg.sv
// Shared encodings and defaults for the HI/LO multiply controller.
// Consumed by hilo_unit and its testbench.
package hilo_pkg;

    localparam int unsigned MUL_LATENCY_DEF = 33;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // 2'b11 is reserved and reads as zero
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_HI   = 2'd1,
        RD_LO   = 2'd2
    } rdsel_t;

endpackage

// File: rtl/hilo_unit.sv
// HI/LO register file and controller for a fixed-latency iterative multiplier.
// Optional macro MUL_CLEAR_EN adds a CLEAR state that pulses mul_clear before each mul_start.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int unsigned CNT_W       = $clog2(MUL_LATENCY + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic [63:0] mul_product,
    output logic        mul_start,
    output logic        mul_clear,
    input  logic [1:0]  read_sel,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        stall
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               w_capture;

    assign w_capture = (r_state == ST_WAIT) && (r_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (op_start) begin
`ifdef MUL_CLEAR_EN
                    w_state_nxt = ST_CLEAR;
`else
                    w_state_nxt = ST_ISSUE;
`endif
                end
            end
`ifdef MUL_CLEAR_EN
            ST_CLEAR: w_state_nxt = ST_ISSUE;
`endif
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_capture) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Start/clear are decodes of the registered state, never of op_start
    always_comb begin
        busy      = (r_state != ST_IDLE);
        mul_start = (r_state == ST_ISSUE);
`ifdef MUL_CLEAR_EN
        mul_clear = (r_state == ST_CLEAR);
`else
        mul_clear = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_cnt <= CNT_W'(MUL_LATENCY - 1);
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_capture) begin
                r_hi <= mul_product[63:32];
                r_lo <= mul_product[31:0];
            end else if (r_state == ST_IDLE) begin
                if (wr_hi) r_hi <= wr_data;
                if (wr_lo) r_lo <= wr_data;
            end
        end
    end

    always_comb begin
        case (rdsel_t'(read_sel))
            RD_HI:   rd_data = r_hi;
            RD_LO:   rd_data = r_lo;
            default: rd_data = '0;
        endcase
    end

    assign stall = busy && (op_start || (read_sel != RD_NONE) || wr_hi || wr_lo);

endmodule
